// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared CPU/cache types and controller-local state for the two-CPU coherence controller.
package coherence_bus_ctrl_pkg;
  localparam int CPUS     = 2;
  localparam int BLKWORDS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcachef_t;

  typedef logic [$clog2(BLKWORDS)-1:0] widx_t;
  localparam widx_t WIDX_LAST = widx_t'(BLKWORDS - 1);

  typedef enum logic [2:0] {
    IDLE, SNOOP, C2C0, C2C1, RAMRD, RAMWR, INVDONE, IFETCH
  } cbc_state_t;
endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Cache-pair and RAM signals of the coherence controller; master is the controller side.
interface coherence_bus_ctrl_if;
  import coherence_bus_ctrl_pkg::*;

  logic [CPUS-1:0]  iREN, iwait;
  word_t [CPUS-1:0] iaddr, iload;
  logic [CPUS-1:0]  dREN, dWEN, dwait;
  word_t [CPUS-1:0] daddr, dstore, dload;
  logic [CPUS-1:0]  cctrans, ccwrite, ccwait, ccinv;
  word_t [CPUS-1:0] ccsnoopaddr;
  logic             ramREN, ramWEN;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter: ptr names the CPU that wins a tie; it moves to the
// other CPU when the granted transaction completes.
module coherence_bus_ctrl_rr_arbiter (
  input  logic       CLK,
  input  logic       nRST,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       done_idx,
  output logic       gnt_idx
);
  logic ptr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~done_idx;
    end
  end

  always_comb begin
    gnt_idx = ptr;
    if (req == 2'b01) begin
      gnt_idx = 1'b0;
    end else if (req == 2'b10) begin
      gnt_idx = 1'b1;
    end
  end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-CPU memory/coherence controller: arbitrates fetch, data, writeback and snoop
// traffic onto a single-ported RAM, one transaction at a time.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
(
  input logic                  CLK,
  input logic                  nRST,
  coherence_bus_ctrl_if.master bus
);
  cbc_state_t      state;
  logic            gnt;
  logic            oth;
  widx_t           widx;
  logic [CPUS-1:0] dreq, req_v;
  logic            arb_idx, ram_done, snoop_dirty, alive, to_idle;
  word_t           blk_addr;

  assign oth         = ~gnt;
  assign dreq        = bus.dREN | bus.dWEN | bus.cctrans;
  assign req_v       = (|dreq) ? dreq : bus.iREN;
  assign ram_done    = (bus.ramstate == ACCESS);
  assign snoop_dirty = bus.cctrans[oth] & bus.ccwrite[oth];

  coherence_bus_ctrl_rr_arbiter u_arb (
    .CLK      (CLK),
    .nRST     (nRST),
    .req      (req_v),
    .update   (to_idle),
    .done_idx (gnt),
    .gnt_idx  (arb_idx)
  );

  // Block-word address: the controller, not the cache, owns the word index.
  always_comb begin
    blk_addr = bus.daddr[gnt];
    case (state)
      C2C1:    blk_addr[2] = 1'b1;
      RAMRD:   blk_addr[2] = widx;
      default: blk_addr[2] = 1'b0;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    alive = 1'b1;
      IFETCH:  alive = bus.iREN[gnt];
      RAMWR:   alive = bus.dWEN[gnt];
      default: alive = bus.dREN[gnt] | bus.cctrans[gnt];
    endcase
    to_idle = 1'b0;
    if (state != IDLE) begin
      if (!alive) begin
        to_idle = 1'b1;
      end else begin
        case (state)
          C2C1, RAMWR, IFETCH: to_idle = ram_done;
          RAMRD:               to_idle = ram_done && (widx == WIDX_LAST);
          INVDONE:             to_idle = 1'b1;
          default:             to_idle = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      gnt   <= 1'b0;
      widx  <= '0;
    end else if (to_idle) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|req_v) begin
            gnt  <= arb_idx;
            widx <= '0;
            if (|dreq) begin
              state <= (bus.dWEN[arb_idx] & ~bus.cctrans[arb_idx]) ? RAMWR : SNOOP;
            end else begin
              state <= IFETCH;
            end
          end
        end
        SNOOP: begin
          if (snoop_dirty)        state <= C2C0;
          else if (bus.dREN[gnt]) state <= RAMRD;
          else                    state <= INVDONE;
        end
        C2C0:    if (ram_done) state <= C2C1;
        RAMRD:   if (ram_done) widx <= widx + widx_t'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    if (state != IDLE && alive) begin
      // The snooped cache stays parked from the snoop until the block is finished.
      if (state inside {SNOOP, C2C0, C2C1, RAMRD, INVDONE}) begin
        bus.ccwait[oth]      = 1'b1;
        bus.ccsnoopaddr[oth] = bus.daddr[gnt];
        bus.ccinv[oth]       = bus.ccwrite[gnt];
      end
      case (state)
        C2C0, C2C1: begin
          bus.ramWEN     = 1'b1;
          bus.ramaddr    = blk_addr;
          bus.ramstore   = bus.dstore[oth];
          bus.dload[gnt] = bus.dstore[oth];
          if (ram_done) begin
            bus.dwait[gnt] = 1'b0;
            bus.dwait[oth] = 1'b0;
          end
        end
        RAMRD: begin
          bus.ramREN     = 1'b1;
          bus.ramaddr    = blk_addr;
          bus.dload[gnt] = bus.ramload;
          if (ram_done) bus.dwait[gnt] = 1'b0;
        end
        RAMWR: begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[gnt];
          bus.ramstore = bus.dstore[gnt];
          if (ram_done) bus.dwait[gnt] = 1'b0;
        end
        INVDONE: bus.dwait[gnt] = 1'b0;
        IFETCH: begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr[gnt];
          if (ram_done) begin
            bus.iwait[gnt] = 1'b0;
            bus.iload[gnt] = bus.ramload;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: bench acts as both caches and the RAM.
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;

  coherence_bus_ctrl_if bus();

  coherence_bus_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.cctrans  = '0;
    bus.ccwrite  = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic chk_rst(input string p);
    chk({p, ".iwait"},    bus.iwait,       2'b11);
    chk({p, ".dwait"},    bus.dwait,       2'b11);
    chk({p, ".ccwait"},   bus.ccwait,      2'b00);
    chk({p, ".ccinv"},    bus.ccinv,       2'b00);
    chk({p, ".ramREN"},   bus.ramREN,      1'b0);
    chk({p, ".ramWEN"},   bus.ramWEN,      1'b0);
    chk({p, ".ramaddr"},  bus.ramaddr,     32'h0);
    chk({p, ".ramstore"}, bus.ramstore,    32'h0);
    chk({p, ".dload"},    bus.dload,       64'h0);
    chk({p, ".iload"},    bus.iload,       64'h0);
    chk({p, ".snpaddr"},  bus.ccsnoopaddr, 64'h0);
  endtask

  initial begin
    nRST = 1'b0;
    clr();
    #12;
    chk_rst("reset");
    nRST = 1'b1;

    // Coherent read miss, CPU1 clean, two BUSY cycles before each ACCESS.
    cyc(); bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h80; bus.ramstate = BUSY;
    #2; chk("miss.idle.ccwait", bus.ccwait, 2'b00);
    cyc(); #2;
    chk("miss.snp.ccwait", bus.ccwait, 2'b10);
    chk("miss.snp.addr", bus.ccsnoopaddr, 64'h00000080_00000000);
    chk("miss.snp.ccinv", bus.ccinv, 2'b00);
    chk("miss.snp.ramREN", bus.ramREN, 1'b0);
    cyc(); #2;
    chk("miss.w0.ramREN", bus.ramREN, 1'b1);
    chk("miss.w0.ramaddr", bus.ramaddr, 32'h80);
    chk("miss.w0.busy.dwait", bus.dwait, 2'b11);
    cyc(); #2; chk("miss.w0.busy2.dwait", bus.dwait, 2'b11);
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h1111_0080;
    #2;
    chk("miss.w0.dwait", bus.dwait, 2'b10);
    chk("miss.w0.dload", bus.dload, 64'h00000000_11110080);
    cyc(); bus.ramstate = BUSY;
    #2;
    chk("miss.w1.ramaddr", bus.ramaddr, 32'h84);
    chk("miss.w1.busy.dwait", bus.dwait, 2'b11);
    chk("miss.w1.ccwait", bus.ccwait, 2'b10);
    cyc();
    cyc(); bus.ramstate = ACCESS; bus.ramload = 32'h2222_0084;
    #2;
    chk("miss.w1.dwait", bus.dwait, 2'b10);
    chk("miss.w1.dload", bus.dload, 64'h00000000_22220084);
    cyc(); clr();
    #2;
    chk("miss.end.ccwait", bus.ccwait, 2'b00);
    chk("miss.end.ramREN", bus.ramREN, 1'b0);

    // Read miss hitting a dirty block in CPU1: cache-to-cache plus RAM writeback.
    cyc(); bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h80;
    cyc(); bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.dstore[1] = 32'hAAAA; bus.ramstate = BUSY;
    #2; chk("c2c.snp.ccwait", bus.ccwait, 2'b10);
    cyc(); #2;
    chk("c2c.w0.ramWEN", bus.ramWEN, 1'b1);
    chk("c2c.w0.ramaddr", bus.ramaddr, 32'h80);
    chk("c2c.w0.ramstore", bus.ramstore, 32'hAAAA);
    chk("c2c.w0.dload", bus.dload, 64'h00000000_0000AAAA);
    chk("c2c.w0.busy.dwait", bus.dwait, 2'b11);
    chk("c2c.w0.ccinv", bus.ccinv, 2'b00);
    cyc(); bus.ramstate = ACCESS;
    #2; chk("c2c.w0.dwait", bus.dwait, 2'b00);
    cyc(); bus.dstore[1] = 32'hBBBB;
    #2;
    chk("c2c.w1.ramaddr", bus.ramaddr, 32'h84);
    chk("c2c.w1.ramstore", bus.ramstore, 32'hBBBB);
    chk("c2c.w1.dload", bus.dload, 64'h00000000_0000BBBB);
    chk("c2c.w1.dwait", bus.dwait, 2'b00);
    cyc(); clr();
    #2;
    chk("c2c.end.ramWEN", bus.ramWEN, 1'b0);
    chk("c2c.end.ccwait", bus.ccwait, 2'b00);

    // Upgrade to M with CPU1 clean: invalidate only, no RAM traffic.
    cyc(); bus.cctrans[0] = 1'b1; bus.ccwrite[0] = 1'b1; bus.daddr[0] = 32'h40;
    cyc(); #2;
    chk("upg.snp.ccinv", bus.ccinv, 2'b10);
    chk("upg.snp.addr", bus.ccsnoopaddr, 64'h00000040_00000000);
    chk("upg.snp.ccwait", bus.ccwait, 2'b10);
    cyc(); #2;
    chk("upg.inv.dwait", bus.dwait, 2'b10);
    chk("upg.inv.ramREN", bus.ramREN, 1'b0);
    chk("upg.inv.ramWEN", bus.ramWEN, 1'b0);
    cyc(); clr();
    #2;
    chk("upg.end.dwait", bus.dwait, 2'b11);
    chk("upg.end.ccinv", bus.ccinv, 2'b00);

    // Plain eviction from CPU1.
    cyc(); bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h100; bus.dstore[1] = 32'h1234; bus.ramstate = BUSY;
    cyc(); #2;
    chk("wb.ramWEN", bus.ramWEN, 1'b1);
    chk("wb.ramaddr", bus.ramaddr, 32'h100);
    chk("wb.ramstore", bus.ramstore, 32'h1234);
    chk("wb.busy.dwait", bus.dwait, 2'b11);
    chk("wb.ccwait", bus.ccwait, 2'b00);
    cyc(); bus.ramstate = ACCESS;
    #2; chk("wb.dwait", bus.dwait, 2'b01);
    cyc(); clr();

    // Both CPUs reading plus an icache fetch: data alternates, icache waits.
    cyc();
    bus.dREN = 2'b11; bus.daddr[0] = 32'h200; bus.daddr[1] = 32'h300;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h400;
    bus.ramstate = ACCESS; bus.ramload = 32'hCAFE_0000;
    cyc(); #2;
    chk("rr1.ccwait", bus.ccwait, 2'b10);
    chk("rr1.snpaddr", bus.ccsnoopaddr, 64'h00000200_00000000);
    cyc(); #2;
    chk("rr1.w0.dwait", bus.dwait, 2'b10);
    chk("rr1.w0.ramaddr", bus.ramaddr, 32'h200);
    chk("rr1.w0.dload", bus.dload, 64'h00000000_CAFE0000);
    cyc(); #2;
    chk("rr1.w1.ramaddr", bus.ramaddr, 32'h204);
    chk("rr1.iwait", bus.iwait, 2'b11);
    cyc(); #2; chk("rr.gap1.ramREN", bus.ramREN, 1'b0);
    cyc(); #2;
    chk("rr2.ccwait", bus.ccwait, 2'b01);
    chk("rr2.snpaddr", bus.ccsnoopaddr, 64'h00000000_00000300);
    cyc(); #2;
    chk("rr2.w0.dwait", bus.dwait, 2'b01);
    chk("rr2.w0.ramaddr", bus.ramaddr, 32'h300);
    chk("rr2.w0.dload", bus.dload, 64'hCAFE0000_00000000);
    cyc(); #2;
    chk("rr2.w1.ramaddr", bus.ramaddr, 32'h304);
    chk("rr2.iwait", bus.iwait, 2'b11);
    cyc(); #2; chk("rr.gap2.iwait", bus.iwait, 2'b11);
    cyc(); #2; chk("rr3.ccwait", bus.ccwait, 2'b10);
    cyc(); #2; chk("rr3.w0.ramaddr", bus.ramaddr, 32'h200);
    cyc(); #2; chk("rr3.w1.ramaddr", bus.ramaddr, 32'h204);
    cyc(); bus.dREN = 2'b00;
    cyc(); #2;
    chk("if.ramREN", bus.ramREN, 1'b1);
    chk("if.ramaddr", bus.ramaddr, 32'h400);
    chk("if.iwait", bus.iwait, 2'b10);
    chk("if.iload", bus.iload, 64'h00000000_CAFE0000);
    chk("if.dwait", bus.dwait, 2'b11);
    cyc(); clr();

    // Reset asserted in the second C2C word; afterwards a tie goes to CPU0 again.
    cyc(); bus.dREN[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h80; bus.ramstate = ACCESS;
    cyc(); bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.dstore[1] = 32'hAAAA;
    cyc();
    cyc(); bus.ramstate = BUSY; bus.dstore[1] = 32'hBBBB;
    #2;
    chk("rst.c2c1.ramWEN", bus.ramWEN, 1'b1);
    chk("rst.c2c1.ramaddr", bus.ramaddr, 32'h84);
    nRST = 1'b0;
    #1;
    chk_rst("midrst");
    clr();
    nRST = 1'b1;
    cyc(); bus.dREN = 2'b11; bus.daddr[0] = 32'h500; bus.daddr[1] = 32'h600; bus.ramstate = BUSY;
    #2; chk("rst.idle.ccwait", bus.ccwait, 2'b00);
    cyc(); #2;
    chk("rst.tie.ccwait", bus.ccwait, 2'b10);
    chk("rst.tie.snpaddr", bus.ccsnoopaddr, 64'h00000500_00000000);
    clr();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
